// File: rtl/piso_serializer_if.sv
// Byte handshake and serial line bundle between the upstream source,
// the piso_serializer stage and the downstream decoder.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] dataIn;
  logic             dataValid;
  logic             dataReady;
  logic             serialOut;
  logic             frameStart;
  logic             lineValid;
  logic             busy;

  modport master (
    output dataIn, dataValid,
    input  dataReady, serialOut, frameStart, lineValid, busy
  );

  modport slave (
    input  dataIn, dataValid,
    output dataReady, serialOut, frameStart, lineValid, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage: small byte FIFO feeding an LSB-first
// shifter that emits bytes in contiguous 8-cycle slots with a frameStart strobe.
module piso_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  piso_serializer_if.slave  bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             not_empty;
  logic             push;
  logic             load;
  logic [WIDTH-1:0] head;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [2:0]       bitCnt;
  logic             serial_q;
  logic             frame_q;
  logic             line_q;

  assign full      = (count == CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = bus.dataValid && !full;
  assign head      = mem[rd_ptr];
  // Decision uses pre-edge occupancy, so a byte pushed this edge cannot be loaded yet.
  assign load      = not_empty && ((state == IDLE) || (bitCnt == 3'd7));

  assign bus.dataReady  = !full;
  assign bus.busy       = not_empty || (state == SHIFT);
  assign bus.serialOut  = serial_q;
  assign bus.frameStart = frame_q;
  assign bus.lineValid  = line_q;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.dataIn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bitCnt   <= '0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end else if (load) begin
      state    <= SHIFT;
      shreg    <= head;
      bitCnt   <= '0;
      serial_q <= head[0];
      frame_q  <= 1'b1;
      line_q   <= 1'b1;
    end else if ((state == SHIFT) && (bitCnt != 3'd7)) begin
      bitCnt   <= bitCnt + 3'd1;
      serial_q <= shreg[bitCnt + 3'd1];
      frame_q  <= 1'b0;
      line_q   <= 1'b1;
    end else begin
      // Drain after bit 7 with nothing queued, or plain idle.
      state    <= IDLE;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
    end
  end
endmodule
